// File: rtl/iter_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : iter_shifter
//  Description : Multi-cycle logarithmic shifter for the execute stage. The
//                five fixed-distance stages (16, 8, 4, 2, 1) are applied one
//                per clock, each gated by its shift-amount bit, so the ALU
//                shift path is removed from the single-cycle critical path.
//                Valid/ready handshake on both the request and result sides.
//
//  Ports       : clock     - single clock, rising-edge active
//                reset_n   - synchronous active-low reset
//                start     - request valid, accepted only while in_ready=1
//                data_in   - operand
//                shamt     - shift amount, 0..DATA_W-1
//                op        - 00=sll, 01=sra, 10=srl, 11=rotate-left
//                in_ready  - high only while idle
//                out_valid - result valid (DONE state)
//                out_ready - consumer accepts result
//                result    - registered accumulator / shifted value
//                busy      - high while shifting or holding a result
//
//  Build option: SHIFTER_SKIP_EN - when defined, stages whose shamt bit is 0
//                are skipped; latency becomes max(1, popcount(shamt)).
//                Results are identical in both builds.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module iter_shifter #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result,
    output logic               busy
);

    // Stage index width: must hold 0..SHAMT_W-1.
    localparam int c_K_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    localparam logic [c_K_W-1:0] c_K_TOP = c_K_W'(SHAMT_W - 1);

    localparam logic [1:0] c_OP_SLL  = 2'b00;
    localparam logic [1:0] c_OP_SRA  = 2'b01;
    localparam logic [1:0] c_OP_SRL  = 2'b10;
    localparam logic [1:0] c_OP_ROTL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [DATA_W-1:0]   r_acc;
    logic [SHAMT_W-1:0]  r_shamt;
    logic [1:0]          r_op;
    logic [c_K_W-1:0]    r_k;

    state_t              w_state_nxt;
    logic [DATA_W-1:0]   w_acc_nxt;
    logic [SHAMT_W-1:0]  w_shamt_nxt;
    logic [1:0]          w_op_nxt;
    logic [c_K_W-1:0]    w_k_nxt;

    // ------------------------------------------------------------------
    // Fixed-distance stage results, one per shift-amount bit. Stage gi
    // shifts the current accumulator by 2**gi using the latched op.
    // ------------------------------------------------------------------
    logic [SHAMT_W-1:0][DATA_W-1:0] w_stage;

    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
        localparam int D = 2 ** gi;

        logic [DATA_W-1:0] w_sll;
        logic [DATA_W-1:0] w_srl;
        logic [DATA_W-1:0] w_sra;
        logic [DATA_W-1:0] w_rotl;

        assign w_sll  = {r_acc[DATA_W-1-D:0], {D{1'b0}}};
        assign w_srl  = {{D{1'b0}}, r_acc[DATA_W-1:D]};
        assign w_sra  = {{D{r_acc[DATA_W-1]}}, r_acc[DATA_W-1:D]};
        assign w_rotl = {r_acc[DATA_W-1-D:0], r_acc[DATA_W-1:DATA_W-D]};

        assign w_stage[gi] = (r_op == c_OP_SLL) ? w_sll  :
                             (r_op == c_OP_SRA) ? w_sra  :
                             (r_op == c_OP_SRL) ? w_srl  :
                                                  w_rotl;
    end

    // Select the stage and its enable bit for the current index. Done as
    // a compare loop so out-of-range index values simply select nothing.
    logic [DATA_W-1:0] w_stage_sel;
    logic              w_stage_en;

    always_comb begin
        w_stage_sel = r_acc;
        w_stage_en  = 1'b0;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (int'(r_k) == i) begin
                w_stage_sel = w_stage[i];
                w_stage_en  = r_shamt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage-index sequencing
    //   w_first_k : index loaded on accept
    //   w_next_k  : index for the following SHIFT cycle
    //   w_last    : current SHIFT cycle is the final one
    // ------------------------------------------------------------------
    logic [c_K_W-1:0] w_first_k;
    logic [c_K_W-1:0] w_next_k;
    logic             w_last;

`ifdef SHIFTER_SKIP_EN
    // Jump straight between set bits. A zero shift amount still spends one
    // SHIFT cycle at index 0 (bit clear, accumulator unchanged).
    always_comb begin
        w_first_k = '0;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (shamt[i]) begin
                w_first_k = c_K_W'(i);
            end
        end

        w_next_k = '0;
        w_last   = 1'b1;
        for (int i = 0; i < SHAMT_W; i++) begin
            if ((i < int'(r_k)) && r_shamt[i]) begin
                w_next_k = c_K_W'(i);
                w_last   = 1'b0;
            end
        end
    end
`else
    // Walk every stage from the top bit down: fixed SHAMT_W-cycle latency.
    always_comb begin
        w_first_k = c_K_TOP;
        w_next_k  = r_k - c_K_W'(1);
        w_last    = (r_k == '0);
    end
`endif

    // ------------------------------------------------------------------
    // Next-state / next-datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_shamt_nxt = r_shamt;
        w_op_nxt    = r_op;
        w_k_nxt     = r_k;

        case (r_state)
            S_IDLE: begin
                // Operands are only sampled here; later input changes
                // cannot affect an operation in flight.
                if (start) begin
                    w_acc_nxt   = data_in;
                    w_shamt_nxt = shamt;
                    w_op_nxt    = op;
                    w_k_nxt     = w_first_k;
                    w_state_nxt = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (w_stage_en) begin
                    w_acc_nxt = w_stage_sel;
                end
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_k_nxt = w_next_k;
                end
            end

            S_DONE: begin
                // Result holds until the consumer takes it; the IDLE cycle
                // that follows is what prevents back-to-back issue.
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_shamt <= '0;
            r_op    <= c_OP_SLL;
            r_k     <= c_K_TOP;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_shamt <= w_shamt_nxt;
            r_op    <= w_op_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded directly from the registered state)
    // ------------------------------------------------------------------
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
    assign result    = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_iter_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iter_shifter
//  Description : Directed, table-driven bench for iter_shifter with hand-
//                written sequences for backpressure and mid-shift reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_shifter;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRA  = 2'b01;
    localparam logic [1:0] OP_SRL  = 2'b10;
    localparam logic [1:0] OP_ROTL = 2'b11;

    logic               clock;
    logic               reset_n;
    logic               start;
    logic [DATA_W-1:0]  data_in;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         op;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  result;
    logic               busy;

    int n_pass  = 0;
    int n_total = 0;

    iter_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .data_in   (data_in),
        .shamt     (shamt),
        .op        (op),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        string              name;
        logic [1:0]         op;
        logic [DATA_W-1:0]  data;
        logic [SHAMT_W-1:0] shamt;
        logic [DATA_W-1:0]  exp;
    } vec_t;

    localparam int N_VEC = 16;
    vec_t vecs [N_VEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input logic [SHAMT_W-1:0] s);
`ifdef SHIFTER_SKIP_EN
        int pc;
        pc = $countones(s);
        return (pc < 1) ? 1 : pc;
`else
        return SHAMT_W;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One complete transaction with out_ready held high.
    task automatic run_op(input string name, input logic [1:0] o, input logic [DATA_W-1:0] d,
                          input logic [SHAMT_W-1:0] s, input logic [DATA_W-1:0] e);
        int lat;
        check({name, " in_ready before"}, {31'b0, in_ready}, 32'd1);
        op        = o;
        data_in   = d;
        shamt     = s;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        // Scramble inputs after accept: they must not matter.
        start   = 1'b0;
        data_in = 32'hA5A5_A5A5;
        shamt   = 5'h15;
        op      = ~o;
        lat     = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_latency(s)));
        check({name, " result"}, result, e);
        tick();
        check({name, " out_valid after hs"}, {31'b0, out_valid}, 32'd0);
        check({name, " in_ready after hs"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;

        vecs[0]  = '{"sll 1<<2",          OP_SLL,  32'h0000_0001, 5'd2,  32'h0000_0004};
        vecs[1]  = '{"sra msb 31",        OP_SRA,  32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        vecs[2]  = '{"srl msb 31",        OP_SRL,  32'h8000_0000, 5'd31, 32'h0000_0001};
        vecs[3]  = '{"sll msb 31",        OP_SLL,  32'h8000_0000, 5'd31, 32'h0000_0000};
        vecs[4]  = '{"rotl 80000001 1",   OP_ROTL, 32'h8000_0001, 5'd1,  32'h0000_0003};
        vecs[5]  = '{"rotl 12345678 16",  OP_ROTL, 32'h1234_5678, 5'd16, 32'h5678_1234};
        vecs[6]  = '{"srl shamt0",        OP_SRL,  32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[7]  = '{"sll shamt0",        OP_SLL,  32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[8]  = '{"sra shamt0",        OP_SRA,  32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[9]  = '{"rotl shamt0",       OP_ROTL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[10] = '{"sra F0000000 4",    OP_SRA,  32'hF000_0000, 5'd4,  32'hFF00_0000};
        vecs[11] = '{"srl F0000000 4",    OP_SRL,  32'hF000_0000, 5'd4,  32'h0F00_0000};
        vecs[12] = '{"sll F 17",          OP_SLL,  32'h0000_000F, 5'd17, 32'h001E_0000};
        vecs[13] = '{"rotl 80000001 17",  OP_ROTL, 32'h8000_0001, 5'd17, 32'h0003_0000};
        vecs[14] = '{"sra 7FFFFFFF 4",    OP_SRA,  32'h7FFF_FFFF, 5'd4,  32'h07FF_FFFF};
        vecs[15] = '{"rotl F000000F 4",   OP_ROTL, 32'hF000_000F, 5'd4,  32'h0000_00FF};

        reset_n   = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        shamt     = '0;
        op        = OP_SLL;
        tick();
        tick();
        check("reset in_ready",  {31'b0, in_ready},  32'd1);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset busy",      {31'b0, busy},      32'd0);
        check("reset result",    result,             32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < N_VEC; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].data, vecs[i].shamt, vecs[i].exp);
        end

        // Backpressure: hold result in DONE while start pulses with new data.
        op        = OP_SLL;
        data_in   = 32'h0000_0001;
        shamt     = 5'd3;
        start     = 1'b1;
        out_ready = 1'b0;
        tick();
        start = 1'b0;
        lat   = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("bp latency", 32'(lat), 32'(exp_latency(5'd3)));
        for (int c = 0; c < 3; c++) begin
            start   = 1'b1;
            data_in = 32'hFFFF_FFFF;
            shamt   = 5'd1;
            check("bp out_valid", {31'b0, out_valid}, 32'd1);
            check("bp result",    result,             32'h0000_0008);
            check("bp in_ready",  {31'b0, in_ready},  32'd0);
            check("bp busy",      {31'b0, busy},      32'd1);
            tick();
        end
        check("bp still valid", {31'b0, out_valid}, 32'd1);
        check("bp still result", result, 32'h0000_0008);
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp hs out_valid", {31'b0, out_valid}, 32'd0);
        check("bp hs in_ready",  {31'b0, in_ready},  32'd1);
        check("bp hs busy",      {31'b0, busy},      32'd0);
        check("bp hs result",    result,             32'h0000_0008);
        tick();
        check("bp no queued op", {31'b0, busy}, 32'd0);

        // Reset in the middle of SHIFT, after two stages.
        op      = OP_SLL;
        data_in = 32'h0000_0001;
        shamt   = 5'd31;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("mid busy before reset", {31'b0, busy}, 32'd1);
        reset_n   = 1'b0;
        out_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        check("rst out_valid", {31'b0, out_valid}, 32'd0);
        check("rst busy",      {31'b0, busy},      32'd0);
        check("rst in_ready",  {31'b0, in_ready},  32'd1);
        check("rst result",    result,             32'd0);
        run_op("post-reset sra", OP_SRA, 32'hF000_0000, 5'd4, 32'hFF00_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Multi-cycle logarithmic shifter for the processor's execute stage; consumes the fixed-distance shift stages (by 16, 8, 4, 2 and 1) and applies one stage per clock.
- Selects each stage by one shift-amount bit.
- Exists so the ALU shift path leaves the single-cycle critical path.
- Valid/ready handshake on both sides; the pipeline stalls on in_ready/out_valid.

Parameters:
- DATA_W, 32, operand/result width; must equal 2**SHAMT_W.
- SHAMT_W, 5, shift-amount width; equals the number of stages.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- start  in  1  request valid; accepted only when in_ready=1.
- data_in  in  DATA_W  operand.
- shamt  in  SHAMT_W  shift amount, 0..DATA_W-1.
- op  in  2  00=sll, 01=sra, 10=srl, 11=rotate-left.
- in_ready  out  1  high only in IDLE.
- out_valid  out  1  result valid, high only in DONE.
- out_ready  in  1  consumer accepts result.
- result  out  DATA_W  shifted value, registered.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset (reset_n=0 at an edge):
  - state=IDLE, result=0, out_valid=0, busy=0, in_ready=1, stage index k=SHAMT_W-1.
  - Any in-flight operation is aborted; no output is produced for it.
- FSM: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge captures data_in into the accumulator (result), plus shamt and op.
  - Sets k=SHAMT_W-1, moves to SHIFT.
  - start=0 stays in IDLE.
- SHIFT, one edge per stage:
  - If shamt_q[k]=1, acc <= stage(acc, 2**k, op); otherwise acc is unchanged.
  - k decrements.
  - The edge that processes k=0 moves to DONE.
- Stage arithmetic (distance d):
  - sll: zero-fill low d bits.
  - srl: zero-fill high d bits.
  - sra: replicate acc[DATA_W-1] into high d bits.
  - rotl: {acc[DATA_W-1-d:0], acc[DATA_W-1:DATA_W-d]}.
- Latency: out_valid rises exactly SHAMT_W edges after the accepting edge (5 by default), independent of shamt.
- DONE:
  - out_valid=1; result holds stable until the out_valid && out_ready edge, which moves to IDLE.
  - in_ready rises the cycle after the handshake; no back-to-back issue.
  - If out_ready is already high on DONE entry, the handshake completes on the next edge.
- start while not IDLE: ignored, no queuing; inputs are not sampled outside IDLE.
- shamt=0: result equals data_in for every op.
- result during SHIFT shows intermediate values; it is meaningful only while out_valid=1. After the handshake it keeps its last value until the next accept.
- Simultaneous reset_n=0 with start or out_ready: reset wins.
- op and shamt are latched at accept; input changes after accept have no effect.

Optional Feature:
- Macro SHIFTER_SKIP_EN.
- Defined:
  - SHIFT skips stages whose shamt bit is 0. k jumps to the highest remaining set bit (priority encode of the unprocessed shamt_q bits).
  - The edge processing the lowest set bit moves to DONE.
  - shamt=0 spends one SHIFT cycle, then goes to DONE.
  - Latency = max(1, popcount(shamt)) edges after accept.
- Undefined: fixed SHAMT_W-edge latency as above.
- Results are identical in both builds.

Test Plan:
1. sll data_in=0x00000001 shamt=2, out_ready=1 -> result=0x00000004; out_valid high on edge 5 after accept, 1 cycle wide; in_ready returns 1.
2. data_in=0x80000000 shamt=31: sra -> 0xFFFFFFFF; srl -> 0x00000001; sll -> 0x00000000.
3. rotl data_in=0x80000001 shamt=1 -> 0x00000003; rotl 0x12345678 shamt=16 -> 0x56781234.
4. Backpressure: shamt=3, hold out_ready=0 for 3 DONE cycles while pulsing start with new data -> out_valid and result stay stable, in_ready=0, start ignored. Then out_ready=1 -> one handshake, IDLE.
5. reset_n=0 for one edge during SHIFT (after 2 stages) -> next cycle out_valid=0, busy=0, in_ready=1, result=0. A following sra 0xF0000000 shamt=4 yields 0xFF000000.
6. shamt=0, op=srl, data_in=0xDEADBEEF -> result 0xDEADBEEF. Latency 5 without SHIFTER_SKIP_EN, 1 with it. With it, shamt=0b10001 gives latency 2 and a correct result.
